// File: rtl/core_dec_stage_q.sv
// Decode stage for the Selen RV32I core: fetch-side instruction queue,
// register file with write-back bypass, load-use stall and kill flush.
module core_dec_stage_q #(
   parameter int XLEN     = 32,
   parameter int IQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_val,
   input  logic [31:0]     if_inst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_rdy,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            kill,
   input  logic            ex_rdy,
   output logic            ex_val,
   output logic [XLEN-1:0] ex_pc,
   output logic [6:0]      ex_opc,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_src1,
   output logic [XLEN-1:0] ex_src2,
   output logic [XLEN-1:0] ex_imm,
   output logic            ex_we_rf,
   output logic            ex_is_load,
   output logic            ex_is_store,
   output logic            ex_ill,
   output logic            stall_out
);

   localparam int AW = $clog2(IQ_DEPTH);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(IQ_DEPTH);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic [31:0]     r_q_inst [IQ_DEPTH];
   logic [XLEN-1:0] r_q_pc   [IQ_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [AW:0]     r_cnt;
   logic [XLEN-1:0] r_rf [32];

   logic            w_head_val;
   logic [31:0]     w_inst;
   logic [6:0]      w_opc;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic            w_use1;
   logic            w_use2;
   logic            w_wr;
   logic            w_ld;
   logic            w_st;
   logic            w_ill;
   logic [31:0]     w_imm32;
   logic            w_push;
   logic            w_issue;
   logic [XLEN-1:0] w_src1;
   logic [XLEN-1:0] w_src2;

   assign w_head_val = (r_cnt != '0);
   assign w_inst     = r_q_inst[r_rptr];
   assign w_opc      = w_inst[6:0];
   assign w_rs1      = w_inst[19:15];
   assign w_rs2      = w_inst[24:20];
   assign w_rd       = w_inst[11:7];

   // Classify the head instruction: operand use, immediate, side effects
   always_comb begin
      w_use1  = 1'b0;
      w_use2  = 1'b0;
      w_wr    = 1'b0;
      w_ld    = 1'b0;
      w_st    = 1'b0;
      w_ill   = 1'b0;
      w_imm32 = '0;
      case (w_opc)
         OPC_LOAD: begin
            w_use1  = 1'b1;
            w_wr    = 1'b1;
            w_ld    = 1'b1;
            w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
         end
         OPC_STORE: begin
            w_use1  = 1'b1;
            w_use2  = 1'b1;
            w_st    = 1'b1;
            w_imm32 = {{20{w_inst[31]}}, w_inst[31:25],
                       w_inst[11:7]};
         end
         OPC_BRANCH: begin
            w_use1  = 1'b1;
            w_use2  = 1'b1;
            w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                       w_inst[30:25], w_inst[11:8], 1'b0};
         end
         OPC_JAL: begin
            w_wr    = 1'b1;
            w_imm32 = {{11{w_inst[31]}}, w_inst[31],
                       w_inst[19:12], w_inst[20],
                       w_inst[30:21], 1'b0};
         end
         OPC_JALR, OPC_OPIMM: begin
            w_use1  = 1'b1;
            w_wr    = 1'b1;
            w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
         end
         OPC_OP: begin
            w_use1  = 1'b1;
            w_use2  = 1'b1;
            w_wr    = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            w_wr    = 1'b1;
            w_imm32 = {w_inst[31:12], 12'b0};
         end
         default: w_ill = 1'b1;
      endcase
   end

   // Operand read with same-cycle write-back bypass; x0 is hardwired zero
   always_comb begin
      w_src1 = r_rf[w_rs1];
      w_src2 = r_rf[w_rs2];
      if (wb_we && wb_rd == w_rs1) w_src1 = wb_data;
      if (wb_we && wb_rd == w_rs2) w_src2 = wb_data;
      if (w_rs1 == 5'd0) w_src1 = '0;
      if (w_rs2 == 5'd0) w_src2 = '0;
   end

   assign stall_out = w_head_val && ex_val && ex_is_load
                   && (ex_rd != 5'd0)
                   && ((w_use1 && ex_rd == w_rs1)
                    || (w_use2 && ex_rd == w_rs2));
   assign w_issue = w_head_val && !stall_out && !kill
                 && (!ex_val || ex_rdy);
   assign if_rdy  = (r_cnt < L_DEPTH);
   assign w_push  = if_val && if_rdy && !kill;

   // Queue storage needs no reset: count gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_inst[r_wptr] <= if_inst;
         r_q_pc[r_wptr]   <= if_pc;
      end
   end

   // Queue pointers and occupancy; kill empties the queue outright
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (kill) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push)  r_wptr <= r_wptr + AW'(1);
         if (w_issue) r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_issue)
            r_cnt <= r_cnt + (AW+1)'(1);
         else if (!w_push && w_issue)
            r_cnt <= r_cnt - (AW+1)'(1);
      end
   end

   // Register file; writes land even while kill is asserted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (wb_we && wb_rd != 5'd0) begin
         r_rf[wb_rd] <= wb_data;
      end
   end

   // Execute bundle: kill clears, issue loads, consume leaves a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_val      <= 1'b0;
         ex_pc       <= '0;
         ex_opc      <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_src1     <= '0;
         ex_src2     <= '0;
         ex_imm      <= '0;
         ex_we_rf    <= 1'b0;
         ex_is_load  <= 1'b0;
         ex_is_store <= 1'b0;
         ex_ill      <= 1'b0;
      end else if (kill) begin
         ex_val <= 1'b0;
      end else if (w_issue) begin
         ex_val      <= 1'b1;
         ex_pc       <= r_q_pc[r_rptr];
         ex_opc      <= w_opc;
         ex_funct3   <= w_inst[14:12];
         ex_funct7b5 <= w_inst[30];
         ex_rs1      <= w_rs1;
         ex_rs2      <= w_rs2;
         ex_rd       <= w_rd;
         ex_src1     <= w_src1;
         ex_src2     <= w_src2;
         ex_imm      <= XLEN'($signed(w_imm32));
         ex_we_rf    <= w_wr && (w_rd != 5'd0);
         ex_is_load  <= w_ld;
         ex_is_store <= w_st;
         ex_ill      <= w_ill;
      end else if (ex_rdy) begin
         ex_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_core_dec_stage_q.sv
// Directed bench for core_dec_stage_q: decode table plus sequences
// for bypass, load-use, backpressure, kill and asynchronous reset.
module tb_core_dec_stage_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_val;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_rdy;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        kill;
   logic        ex_rdy;
   logic        ex_val;
   logic [31:0] ex_pc;
   logic [6:0]  ex_opc;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [31:0] ex_src1;
   logic [31:0] ex_src2;
   logic [31:0] ex_imm;
   logic        ex_we_rf;
   logic        ex_is_load;
   logic        ex_is_store;
   logic        ex_ill;
   logic        stall_out;

   int errors = 0;
   int checks = 0;

   core_dec_stage_q #(.XLEN(32), .IQ_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .if_val(if_val), .if_inst(if_inst), .if_pc(if_pc),
      .if_rdy(if_rdy),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .kill(kill), .ex_rdy(ex_rdy), .ex_val(ex_val),
      .ex_pc(ex_pc), .ex_opc(ex_opc), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_we_rf(ex_we_rf),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_ill(ex_ill), .stall_out(stall_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        st;
      logic        ill;
      logic        cimm;
   } vec_t;

   vec_t tv [11];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] inst);
      if_val  = 1'b1;
      if_inst = inst;
      if_pc   = 32'h200;
      tick();
      if_val  = 1'b0;
   endtask

   int seen;
   logic [31:0] got [$];

   initial begin
      tv[0]  = '{32'h00500093, 32'h100, 32'h5, 7'h13, 3'd0, 1'b0,
                 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[1]  = '{32'h0000A283, 32'h104, 32'h0, 7'h03, 3'd2, 1'b0,
                 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tv[2]  = '{32'h0020A423, 32'h108, 32'h8, 7'h23, 3'd2, 1'b0,
                 5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tv[3]  = '{32'hFE000EE3, 32'h10C, 32'hFFFFFFFC, 7'h63, 3'd0,
                 1'b1, 5'd0, 5'd0, 5'd29, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1};
      tv[4]  = '{32'h00000FFF, 32'h110, 32'h0, 7'h7F, 3'd0, 1'b0,
                 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[5]  = '{32'h123453B7, 32'h114, 32'h12345000, 7'h37, 3'd5,
                 1'b0, 5'd8, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1};
      tv[6]  = '{32'h001000EF, 32'h118, 32'h800, 7'h6F, 3'd0, 1'b0,
                 5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[7]  = '{32'hFFFFF06F, 32'h11C, 32'hFFFFFFFE, 7'h6F, 3'd7,
                 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1};
      tv[8]  = '{32'h80000517, 32'h120, 32'h80000000, 7'h17, 3'd0,
                 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1};
      tv[9]  = '{32'hFFF18067, 32'h124, 32'hFFFFFFFF, 7'h67, 3'd0,
                 1'b1, 5'd3, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1};
      tv[10] = '{32'h40208233, 32'h128, 32'h0, 7'h33, 3'd0, 1'b1,
                 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; if_val = 1'b0; if_inst = '0; if_pc = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; kill = 1'b0;
      ex_rdy = 1'b1;
      #3;
      chk("rst_if_rdy", {31'b0, if_rdy}, 32'd1);
      chk("rst_stall", {31'b0, stall_out}, 32'd0);
      chk("rst_ex_val", {31'b0, ex_val}, 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("post_rst_if_rdy", {31'b0, if_rdy}, 32'd1);
      chk("post_rst_ex_val", {31'b0, ex_val}, 32'd0);

      // decode table: push, one idle cycle, then ex_* valid
      foreach (tv[k]) begin
         if_val = 1'b1; if_inst = tv[k].inst; if_pc = tv[k].pc;
         tick();
         if_val = 1'b0;
         chk("lat_no_ex_val", {31'b0, ex_val}, 32'd0);
         tick();
         chk($sformatf("v%0d_val", k), {31'b0, ex_val}, 32'd1);
         chk($sformatf("v%0d_pc", k), ex_pc, tv[k].pc);
         chk($sformatf("v%0d_opc", k), {25'b0, ex_opc},
             {25'b0, tv[k].opc});
         chk($sformatf("v%0d_f3", k), {29'b0, ex_funct3},
             {29'b0, tv[k].f3});
         chk($sformatf("v%0d_f7", k), {31'b0, ex_funct7b5},
             {31'b0, tv[k].f7});
         chk($sformatf("v%0d_rs", k),
             {17'b0, ex_rs1, ex_rs2, ex_rd},
             {17'b0, tv[k].rs1, tv[k].rs2, tv[k].rd});
         if (tv[k].cimm)
            chk($sformatf("v%0d_imm", k), ex_imm, tv[k].imm);
         chk($sformatf("v%0d_flags", k),
             {28'b0, ex_we_rf, ex_is_load, ex_is_store, ex_ill},
             {28'b0, tv[k].we, tv[k].ld, tv[k].st, tv[k].ill});
         chk($sformatf("v%0d_src", k), ex_src1 | ex_src2, 32'd0);
      end
      tick();
      chk("table_drain", {31'b0, ex_val}, 32'd0);

      // write-back bypass on the issue cycle, then register file read
      push1(32'h002101B3);
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
      tick();
      wb_we = 1'b0;
      chk("byp_src1", ex_src1, 32'hDEADBEEF);
      chk("byp_src2", ex_src2, 32'hDEADBEEF);
      push1(32'h002101B3);
      tick();
      chk("rf_src1", ex_src1, 32'hDEADBEEF);
      push1(32'h000001B3);
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
      tick();
      wb_we = 1'b0;
      chk("x0_byp", ex_src1 | ex_src2, 32'd0);
      push1(32'h000001B3);
      tick();
      chk("x0_rf", ex_src1 | ex_src2, 32'd0);
      tick();

      // load-use: LW x5 then ADD x6,x5,x5
      if_val = 1'b1; if_inst = 32'h0000A283; if_pc = 32'h300;
      tick();
      if_inst = 32'h00528333; if_pc = 32'h304;
      tick();
      if_val = 1'b0;
      #1;
      chk("lu_load", {30'b0, ex_val, ex_is_load}, 32'd3);
      chk("lu_stall", {31'b0, stall_out}, 32'd1);
      tick();
      chk("lu_bubble", {31'b0, ex_val}, 32'd0);
      chk("lu_stall_off", {31'b0, stall_out}, 32'd0);
      tick();
      chk("lu_dep_val", {31'b0, ex_val}, 32'd1);
      chk("lu_dep_rd", {27'b0, ex_rd}, 32'd6);
      chk("lu_dep_pc", ex_pc, 32'h304);
      tick();

      // backpressure: fill the queue with ex_rdy low
      ex_rdy = 1'b0;
      if_val = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if_inst = 32'h00000093 | ((k + 1) << 20);
         if_pc = 32'h400 + 4 * k;
         tick();
      end
      if_inst = 32'h00400093; if_pc = 32'h40C;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_if_rdy", {31'b0, if_rdy}, 32'd0);
         chk("bp_hold_imm", ex_imm, 32'd1);
         chk("bp_hold_pc", ex_pc, 32'h400);
         tick();
      end
      if_val = 1'b0; ex_rdy = 1'b1;
      got.delete();
      for (int k = 0; k < 6; k++) begin
         if (ex_val) got.push_back(ex_imm);
         tick();
      end
      chk("bp_count", got.size(), 32'd3);
      for (int k = 0; k < got.size() && k < 3; k++)
         chk("bp_order", got[k], k + 1);

      // streaming across pointer wrap at full throughput
      got.delete();
      for (int k = 0; k < 10; k++) begin
         if_val = (k < 6);
         if_inst = 32'h00000093 | ((k + 10) << 20);
         tick();
         if (ex_val) got.push_back(ex_imm);
      end
      if_val = 1'b0;
      chk("st_count", got.size(), 32'd6);
      for (int k = 0; k < got.size() && k < 6; k++)
         chk("st_order", got[k], k + 10);

      // kill while full with a concurrent push
      ex_rdy = 1'b0; if_val = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if_inst = 32'h00000093 | ((k + 32'h41) << 20);
         tick();
      end
      chk("kill_pre", {30'b0, ex_val, if_rdy}, 32'd2);
      kill = 1'b1; if_inst = 32'h04400093;
      tick();
      kill = 1'b0; if_val = 1'b0; ex_rdy = 1'b1;
      #1;
      chk("kill_ex_val", {31'b0, ex_val}, 32'd0);
      chk("kill_if_rdy", {31'b0, if_rdy}, 32'd1);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (ex_val) seen++;
      end
      chk("kill_no_issue", seen, 32'd0);

      // kill on empty queue drops the push but keeps the rf write
      if_val = 1'b1; if_inst = 32'h00700093; kill = 1'b1;
      wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h0BADF00D;
      tick();
      kill = 1'b0; if_val = 1'b0; wb_we = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ex_val) seen++;
      end
      chk("kill_drop_push", seen, 32'd0);
      push1(32'h009481B3);
      tick();
      chk("kill_rf_write", ex_src1, 32'h0BADF00D);
      tick();

      // asynchronous reset mid-operation
      ex_rdy = 1'b0; if_val = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if_inst = 32'h00000093 | ((k + 32'h51) << 20);
         if_pc = 32'h500 + 4 * k;
         tick();
      end
      if_val = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ex_val", {31'b0, ex_val}, 32'd0);
      chk("arst_if_rdy", {31'b0, if_rdy}, 32'd1);
      chk("arst_ex_pc", ex_pc, 32'd0);
      tick();
      rst = 1'b0; ex_rdy = 1'b1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ex_val) seen++;
      end
      chk("arst_no_issue", seen, 32'd0);
      push1(32'h002101B3);
      tick();
      chk("arst_rf_clear", ex_src1, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
